sap1_output_display: RTL and testbench

Output stage downstream of the SAP-1 datapath. It captures the 8-bit result presented on an OUT strobe and converts it to three BCD digits with a sequential shift-add-3 (double-dabble) engine. It then drives a time-multiplexed 3-digit 7-segment display. It replaces the purely combinational binary display, adding decimal readout and a busy/overrun handshake to the control unit.

---
 rtl/sap1_display_pkg.sv | 33 +++
 rtl/sap1_seg7_decode.sv | 30 +++
 rtl/sap1_output_display.sv | 123 ++++++++++++
 tb/tb_sap1_output_display.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/sap1_display_pkg.sv
// Shared types and constants for the SAP-1 decimal output display.
`timescale 1ns/1ps
package sap1_display_pkg;

  typedef enum logic {IDLE, CONV} state_t;

  localparam int unsigned NUM_DIGITS = 3;

  // Glyph bit order {g,f,e,d,c,b,a}, active-high
  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // One double-dabble iteration over {hundreds,tens,ones,binary[7:0]}
  function automatic logic [19:0] dabble_step(input logic [19:0] sr);
    logic [19:0] adj;
    adj = sr;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (adj[8+4*i +: 4] >= 4'd5)
        adj[8+4*i +: 4] = adj[8+4*i +: 4] + 4'd3;
    end
    return {adj[18:0], 1'b0};
  endfunction

endpackage

// File: rtl/sap1_seg7_decode.sv
// BCD digit to 7-segment glyph with blanking; out-of-range codes show nothing.
`timescale 1ns/1ps
module sap1_seg7_decode
  import sap1_display_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (bcd)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/sap1_output_display.sv
// SAP-1 output stage: latch OUT value, convert to BCD sequentially, and
// scan it onto a 3-digit multiplexed 7-segment display.
`timescale 1ns/1ps
module sap1_output_display
  import sap1_display_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       out_load,
  input  logic [7:0] data_in,
  output logic       busy,
  output logic       overrun,
  output logic [7:0] value_out,
  output logic [6:0] seg,
  output logic [2:0] an
);

  localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);

  state_t      state, state_nxt;
  logic [19:0] shift_q, shift_nxt;
  logic [2:0]  count_q;
  logic [3:0]  hund_q, tens_q, ones_q;
  logic [15:0] presc_q;
  logic [1:0]  idx_q;
  logic        accept, finish;
  logic [3:0]  digit;
  logic        blank;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    finish    = 1'b0;
    shift_nxt = dabble_step(shift_q);
    case (state)
      IDLE: if (out_load) begin
        accept    = 1'b1;
        state_nxt = CONV;
      end
      CONV: if (count_q == 3'd7) begin
        finish    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  assign busy = (state == CONV);

  // Display digits change only on the finishing edge, so the scan never tears
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value_out <= '0;
      shift_q   <= '0;
      count_q   <= '0;
      hund_q    <= '0;
      tens_q    <= '0;
      ones_q    <= '0;
      overrun   <= 1'b0;
    end else begin
      if (accept) begin
        value_out <= data_in;
        shift_q   <= {12'd0, data_in};
        count_q   <= '0;
      end else if (state == CONV) begin
        shift_q <= shift_nxt;
        count_q <= count_q + 3'd1;
      end
      if (finish)
        {hund_q, tens_q, ones_q} <= shift_nxt[19:8];
      if (accept)
        overrun <= 1'b0;
      else if (out_load && state == CONV)
        overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else if (presc_q == SCAN_LAST) begin
      presc_q <= '0;
      idx_q   <= (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    end else begin
      presc_q <= presc_q + 16'd1;
    end
  end

  always_comb begin
    an    = '0;
    digit = ones_q;
    blank = 1'b0;
    case (idx_q)
      2'd0: an = 3'b001;
      2'd1: begin
        an    = 3'b010;
        digit = tens_q;
        blank = (hund_q == 4'd0) && (tens_q == 4'd0);
      end
      2'd2: begin
        an    = 3'b100;
        digit = hund_q;
        blank = (hund_q == 4'd0);
      end
      default: an = '0;
    endcase
  end

  sap1_seg7_decode u_decode (
    .bcd   (digit),
    .blank (blank),
    .seg   (seg)
  );

endmodule

// File: tb/tb_sap1_output_display.sv
// Randomized self-checking bench for sap1_output_display against a decimal model.
`timescale 1ns/1ps
module tb_sap1_output_display;

  localparam int unsigned SCAN_DIV = 4;
  localparam logic [6:0] GLYPH [10] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
    7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
  };

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       out_load = 1'b0;
  logic [7:0] data_in = '0;
  logic       busy, overrun;
  logic [7:0] value_out;
  logic [6:0] seg;
  logic [2:0] an;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int shown = 0;

  sap1_output_display #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk       (clk),
    .reset     (reset),
    .out_load  (out_load),
    .data_in   (data_in),
    .busy      (busy),
    .overrun   (overrun),
    .value_out (value_out),
    .seg       (seg),
    .an        (an)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release drive the expected scan position
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic logic [9:0] exp_disp(input int v);
    int h, t, o, idx;
    logic [2:0] a;
    logic [6:0] s;
    h = v / 100;
    t = (v / 10) % 10;
    o = v % 10;
    idx = (cyc / SCAN_DIV) % 3;
    case (idx)
      0: begin a = 3'b001; s = GLYPH[o]; end
      1: begin a = 3'b010; s = (h == 0 && t == 0) ? 7'b0 : GLYPH[t]; end
      default: begin a = 3'b100; s = (h == 0) ? 7'b0 : GLYPH[h]; end
    endcase
    return {a, s};
  endfunction

  task automatic load(input logic [7:0] v);
    data_in  = v;
    out_load = 1'b1;
    @(posedge clk); #1;
    out_load = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rst_overrun got=%b exp=0", overrun); end
    total++; if (value_out !== 8'd0) begin bad++; $display("FAIL rst_value got=%0d exp=0", value_out); end
    total++; if ({an, seg} !== {3'b001, 7'b0111111}) begin
      bad++; $display("FAIL rst_disp got an=%b seg=%b exp an=001 seg=0111111", an, seg);
    end
  endtask

  task automatic test_scan();
    for (int c = 0; c < 3 * SCAN_DIV + 2; c++) begin
      total++;
      if ({an, seg} !== exp_disp(0)) begin
        bad++; $display("FAIL scan got an=%b seg=%b exp %b", an, seg, exp_disp(0));
      end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL scan_busy got=%b exp=0", busy); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_conversion(input int v);
    load(v[7:0]);
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL conv_overrun v=%0d got=%b exp=0", v, overrun); end
    total++; if (value_out !== v[7:0]) begin bad++; $display("FAIL conv_value got=%0d exp=%0d", value_out, v); end
    for (int i = 0; i < 8; i++) begin
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL conv_busy v=%0d cyc%0d got=%b exp=1", v, i, busy); end
      total++;
      if ({an, seg} !== exp_disp(shown)) begin
        bad++; $display("FAIL conv_hold v=%0d got an=%b seg=%b exp %b", v, an, seg, exp_disp(shown));
      end
      @(posedge clk); #1;
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL conv_done v=%0d busy got=%b exp=0", v, busy); end
    shown = v;
    for (int c = 0; c < 3 * SCAN_DIV; c++) begin
      total++;
      if ({an, seg} !== exp_disp(v)) begin
        bad++; $display("FAIL conv_disp v=%0d got an=%b seg=%b exp %b", v, an, seg, exp_disp(v));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_overrun();
    int n;
    load(8'd42);
    repeat (2) begin @(posedge clk); #1; end
    data_in = 8'd99; out_load = 1'b1;
    @(posedge clk); #1;
    out_load = 1'b0;
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set got=%b exp=1", overrun); end
    total++; if (value_out !== 8'd42) begin bad++; $display("FAIL ovr_value got=%0d exp=42", value_out); end
    n = 0;
    while (busy === 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ovr_timeout busy got=%b exp=0", busy); end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
    for (int c = 0; c < 3 * SCAN_DIV; c++) begin
      total++;
      if ({an, seg} !== exp_disp(42)) begin
        bad++; $display("FAIL ovr_disp42 got an=%b seg=%b exp %b", an, seg, exp_disp(42));
      end
      @(posedge clk); #1;
    end
    load(8'd99);
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b exp=0", overrun); end
    total++; if (value_out !== 8'd99) begin bad++; $display("FAIL ovr_value99 got=%0d exp=99", value_out); end
    n = 0;
    while (busy === 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ovr_timeout2 busy got=%b exp=0", busy); end
    for (int c = 0; c < 3 * SCAN_DIV; c++) begin
      total++;
      if ({an, seg} !== exp_disp(99)) begin
        bad++; $display("FAIL ovr_disp99 got an=%b seg=%b exp %b", an, seg, exp_disp(99));
      end
      @(posedge clk); #1;
    end
    shown = 99;
  endtask

  task automatic test_reset_mid_conv();
    load(8'd128);
    repeat (4) begin @(posedge clk); #1; end
    #2 reset = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    total++; if (value_out !== 8'd0) begin bad++; $display("FAIL rmid_value got=%0d exp=0", value_out); end
    @(posedge clk); #1;
    reset = 1'b1;
    shown = 0;
    for (int c = 0; c < 3 * SCAN_DIV; c++) begin
      total++;
      if ({an, seg} !== exp_disp(0)) begin
        bad++; $display("FAIL rmid_disp got an=%b seg=%b exp %b", an, seg, exp_disp(0));
      end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_idle got=%b exp=0", busy); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    int n;
    load(8'd200);
    repeat (7) begin @(posedge clk); #1; end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy7 got=%b exp=1", busy); end
    data_in = 8'd77; out_load = 1'b1;
    @(posedge clk); #1;
    out_load = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_end got=%b exp=0", busy); end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL b2b_overrun got=%b exp=1", overrun); end
    total++; if (value_out !== 8'd200) begin bad++; $display("FAIL b2b_value got=%0d exp=200", value_out); end
    load(8'd13);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept got=%b exp=1", busy); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL b2b_clear got=%b exp=0", overrun); end
    total++; if (value_out !== 8'd13) begin bad++; $display("FAIL b2b_value13 got=%0d exp=13", value_out); end
    n = 0;
    while (busy === 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_timeout busy got=%b exp=0", busy); end
    for (int c = 0; c < 3 * SCAN_DIV; c++) begin
      total++;
      if ({an, seg} !== exp_disp(13)) begin
        bad++; $display("FAIL b2b_disp13 got an=%b seg=%b exp %b", an, seg, exp_disp(13));
      end
      @(posedge clk); #1;
    end
    shown = 13;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b1;
    test_scan();
    test_conversion(255);
    test_conversion(7);
    test_conversion(100);
    test_conversion(0);
    for (int k = 0; k < 8; k++) test_conversion(int'($urandom_range(0, 255)));
    test_overrun();
    test_reset_mid_conv();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
